// File: rtl/pulse_train_pkg.sv
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared state encoding and default widths for pulse_train_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_train_pkg;

    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_NUM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pt_state_t;

endpackage : pulse_train_pkg

`default_nettype wire

// File: rtl/pulse_phase_counter.sv
// ============================================================================
// Module      : pulse_phase_counter
// Description : Loadable down-counter with a zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load wins over decrement so a phase can be re-armed on its final cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : pulse_phase_counter

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// Module      : pulse_train_gen
// Description : Programmable registered pulse-train generator (high/low/count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int NUM_WIDTH = DEF_NUM_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] HIGH_LEN,
    input  logic [CNT_WIDTH-1:0] LOW_LEN,
    input  logic [NUM_WIDTH-1:0] NUM_PULSES,
    output logic                 PULSE_OUT,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_WIDTH-1:0] c_num_one = {{(NUM_WIDTH-1){1'b0}}, 1'b1};

    pt_state_t r_state;
    pt_state_t w_state_nxt;

    logic [CNT_WIDTH-1:0] r_high_len;
    logic [CNT_WIDTH-1:0] r_low_len;
    logic                 r_pulse;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_cfg_latch;
    logic                 w_done_nxt;
    logic                 w_ph_load;
    logic [CNT_WIDTH-1:0] w_ph_value;
    logic                 w_ph_en;
    logic                 w_ph_zero;
    logic                 w_np_load;
    logic [NUM_WIDTH-1:0] w_np_value;
    logic                 w_np_en;
    logic                 w_np_zero;
    logic [CNT_WIDTH-1:0] w_low_load;
    logic                 w_start_ok;

    // A zero LOW_LEN still gets one low cycle so each pulse has both edges.
    assign w_low_load = (r_low_len == '0) ? '0 : (r_low_len - c_cnt_one);
    assign w_start_ok = (NUM_PULSES != '0) && (HIGH_LEN != '0);

    pulse_phase_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_load  (w_ph_load),
        .i_value (w_ph_value),
        .i_en    (w_ph_en),
        .o_zero  (w_ph_zero)
    );

    // Holds pulses still to come after the current HIGH phase.
    pulse_phase_counter #(
        .WIDTH (NUM_WIDTH)
    ) u_pulse_cnt (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_load  (w_np_load),
        .i_value (w_np_value),
        .i_en    (w_np_en),
        .o_zero  (w_np_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_latch = 1'b0;
        w_done_nxt  = 1'b0;
        w_ph_load   = 1'b0;
        w_ph_value  = '0;
        w_ph_en     = 1'b0;
        w_np_load   = 1'b0;
        w_np_value  = '0;
        w_np_en     = 1'b0;

        case (r_state)
            IDLE: begin
                if (START && !ABORT) begin
                    if (w_start_ok) begin
                        w_state_nxt = HIGH;
                        w_cfg_latch = 1'b1;
                        w_ph_load   = 1'b1;
                        w_ph_value  = HIGH_LEN - c_cnt_one;
                        w_np_load   = 1'b1;
                        w_np_value  = NUM_PULSES - c_num_one;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!w_ph_zero) begin
                    w_ph_en = 1'b1;
                end else if (w_np_zero) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = LOW;
                    w_ph_load   = 1'b1;
                    w_ph_value  = w_low_load;
                end
            end
            LOW: begin
                if (!w_ph_zero) begin
                    w_ph_en = 1'b1;
                end else begin
                    w_state_nxt = HIGH;
                    w_ph_load   = 1'b1;
                    w_ph_value  = r_high_len - c_cnt_one;
                    w_np_en     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything, including the completion strobe.
        if (ABORT) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
            w_cfg_latch = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_high_len <= '0;
            r_low_len  <= '0;
        end else if (w_cfg_latch) begin
            r_high_len <= HIGH_LEN;
            r_low_len  <= LOW_LEN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= (w_state_nxt == HIGH);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign PULSE_OUT = r_pulse;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule : pulse_train_gen

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Directed self-checking bench for pulse_train_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        START;
    logic        ABORT;
    logic [15:0] HIGH_LEN;
    logic [15:0] LOW_LEN;
    logic [7:0]  NUM_PULSES;
    logic        PULSE_OUT;
    logic        BUSY;
    logic        DONE;

    int n_cmp = 0;
    int n_err = 0;

    pulse_train_gen #(
        .CNT_WIDTH (16),
        .NUM_WIDTH (8)
    ) u_dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .START      (START),
        .ABORT      (ABORT),
        .HIGH_LEN   (HIGH_LEN),
        .LOW_LEN    (LOW_LEN),
        .NUM_PULSES (NUM_PULSES),
        .PULSE_OUT  (PULSE_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int h, input int l, input int n);
        HIGH_LEN   = 16'(h);
        LOW_LEN    = 16'(l);
        NUM_PULSES = 8'(n);
    endtask

    // Raises START, observes ncyc cycles; wave holds cycle 1 as its leftmost bit.
    task automatic run(input int ncyc, input int hold, input bit mess_cfg,
                       output logic [63:0] wave, output int rises, output int falls,
                       output int busy_cnt, output int done_at, output int done_cnt);
        logic prev;
        wave = '0; rises = 0; falls = 0; busy_cnt = 0; done_at = 0; done_cnt = 0;
        prev = PULSE_OUT;
        START = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (k >= hold) START = 1'b0;
            if (mess_cfg && k == 1) cfg(1, 7, 9);
            wave = {wave[62:0], PULSE_OUT};
            if (!prev && PULSE_OUT) rises++;
            if (prev && !PULSE_OUT) falls++;
            prev = PULSE_OUT;
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                done_at = k;
            end
        end
    endtask

    logic [63:0] wv;
    int r, f, b, da, dc, acc;

    initial begin
        RSTN = 1'b0; START = 1'b1; ABORT = 1'b0;
        cfg(3, 1, 2);

        // Reset held for 3 cycles while START is requested
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outs", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);
        end
        START = 1'b0; RSTN = 1'b1;
        tick();
        chk("post_rst_outs", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);

        // Single pulse
        cfg(3, 5, 1);
        run(6, 1, 1'b0, wv, r, f, b, da, dc);
        chk("single_wave",  wv[5:0], 64'b111000);
        chk("single_rise",  r, 1);
        chk("single_fall",  f, 1);
        chk("single_busy",  b, 3);
        chk("single_done",  da, 4);
        chk("single_dcnt",  dc, 1);

        // Four-pulse train
        cfg(2, 3, 4);
        run(20, 1, 1'b0, wv, r, f, b, da, dc);
        chk("train_wave", wv[19:0], 64'b11000110001100011000);
        chk("train_rise", r, 4);
        chk("train_fall", f, 4);
        chk("train_busy", b, 17);
        chk("train_done", da, 18);
        chk("train_dcnt", dc, 1);

        // Zero low gap clamps to one
        cfg(1, 0, 3);
        run(8, 1, 1'b0, wv, r, f, b, da, dc);
        chk("clamp_wave", wv[7:0], 64'b10101000);
        chk("clamp_rise", r, 3);
        chk("clamp_done", da, 6);
        chk("clamp_busy", b, 5);

        // Zero pulse count, then zero high length
        cfg(4, 2, 0);
        run(4, 1, 1'b0, wv, r, f, b, da, dc);
        chk("zn_wave", wv[3:0], 64'd0);
        chk("zn_busy", b, 0);
        chk("zn_done", da, 1);
        chk("zn_dcnt", dc, 1);
        cfg(0, 2, 3);
        run(4, 1, 1'b0, wv, r, f, b, da, dc);
        chk("zh_wave", wv[3:0], 64'd0);
        chk("zh_done", da, 1);
        chk("zh_dcnt", dc, 1);

        // START held through a train while config changes mid-train
        cfg(3, 2, 2);
        run(10, 8, 1'b1, wv, r, f, b, da, dc);
        chk("iso_wave", wv[9:0], 64'b1110011100);
        chk("iso_busy", b, 8);
        chk("iso_done", da, 9);
        chk("iso_dcnt", dc, 1);

        // Abort during the second HIGH phase
        cfg(2, 1, 4);
        START = 1'b1;
        tick(); START = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_pulse", PULSE_OUT, 1'b1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_outs", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc += int'(PULSE_OUT) + int'(BUSY) + int'(DONE);
        end
        chk("abort_quiet", acc, 0);

        // Abort on the final HIGH cycle suppresses DONE
        cfg(2, 1, 1);
        START = 1'b1;
        tick(); START = 1'b0;
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_last", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);

        // ABORT together with START in IDLE
        cfg(2, 1, 1);
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("abort_start", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);

        // Restart in the DONE cycle
        cfg(1, 0, 1);
        START = 1'b1;
        tick(); START = 1'b0;
        chk("bb_p1", {62'd0, PULSE_OUT, BUSY}, 64'b11);
        tick();
        chk("bb_done", {61'd0, PULSE_OUT, BUSY, DONE}, 64'b001);
        START = 1'b1;
        tick(); START = 1'b0;
        chk("bb_p2", {61'd0, PULSE_OUT, BUSY, DONE}, 64'b110);
        tick();
        chk("bb_done2", DONE, 1'b1);

        // Reset mid-train
        cfg(4, 1, 2);
        START = 1'b1;
        tick(); START = 1'b0;
        tick();
        RSTN = 1'b0;
        tick();
        chk("mid_rst", {61'd0, PULSE_OUT, BUSY, DONE}, 64'd0);
        RSTN = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc += int'(PULSE_OUT) + int'(DONE);
        end
        chk("mid_rst_quiet", acc, 0);

        // Full-scale pulse count
        cfg(1, 1, 255);
        run(512, 1, 1'b0, wv, r, f, b, da, dc);
        chk("full_rise", r, 255);
        chk("full_fall", f, 255);
        chk("full_busy", b, 509);
        chk("full_done", da, 510);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pulse_train_gen

`default_nettype wire
